codec_cfg_sequencer: RTL and testbench

CODEC_CFG_SEQUENCER -- requirements
Module: codec_cfg_sequencer

---
 rtl/codec_cfg_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_codec_cfg_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// codec_cfg_sequencer
//
// Walks a compile-time table of codec register writes through an external I2C
// controller after a start pulse, retrying failed transactions, and afterwards
// serves single software read/write requests through the same controller.
//
// Ports
//   board_clk, resetn        : clock, asynchronous active-low reset
//   start                    : pulse, (re)starts the init table walk
//   sw_rd_en, sw_wr_en       : software request strobes (both high = write)
//   sw_reg_addr, sw_wr_data  : software request address / write byte
//   sw_req_ack               : same-cycle acceptance pulse for a request
//   sw_rd_data, sw_rd_valid  : software read result and its one-cycle pulse
//   sw_error                 : one-cycle pulse, software transaction gave up
//   codec_rd_en, codec_wr_en : one-cycle strobes to the I2C controller
//   codec_reg_addr           : register address to the controller
//   codec_data_in            : write byte to the controller
//   codec_data_out(_valid)   : read byte returned by the controller
//   controller_busy          : controller is running a transaction
//   missed_ack               : controller saw a NACK
//   init_done, init_error    : table walk finished / gave up
//   seq_busy                 : sequencer is running a transaction
//   cmd_index                : current (or last / failing) table entry
// -----------------------------------------------------------------------------
module codec_cfg_sequencer #(
    parameter int                      NUM_CMDS     = 8,
    parameter logic [NUM_CMDS*16-1:0]  CMD_TABLE    = {(NUM_CMDS*16){1'b0}},
    parameter int                      MAX_RETRY    = 3,
    parameter int                      BUSY_TIMEOUT = 4095
) (
    input  logic        board_clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        sw_rd_en,
    input  logic        sw_wr_en,
    input  logic [7:0]  sw_reg_addr,
    input  logic [7:0]  sw_wr_data,
    output logic        sw_req_ack,
    output logic [7:0]  sw_rd_data,
    output logic        sw_rd_valid,
    output logic        sw_error,
    output logic        codec_rd_en,
    output logic        codec_wr_en,
    output logic [7:0]  codec_reg_addr,
    output logic [7:0]  codec_data_in,
    input  logic [7:0]  codec_data_out,
    input  logic        codec_data_out_valid,
    input  logic        controller_busy,
    input  logic        missed_ack,
    output logic        init_done,
    output logic        init_error,
    output logic        seq_busy,
    output logic [5:0]  cmd_index
);

    localparam int               RETRY_W      = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [11:0]      TIMEOUT_LAST = 12'(BUSY_TIMEOUT - 1);
    localparam logic [5:0]       LAST_IDX     = 6'(NUM_CMDS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_CHECK     = 3'd4,
        S_READY     = 3'd5
    } state_t;

    typedef enum logic {
        OWN_INIT = 1'b0,
        OWN_SW   = 1'b1
    } owner_t;

    // Table lookup as a mux over valid entries so an index past the table
    // never selects outside CMD_TABLE.
    function automatic logic [15:0] table_entry(input logic [5:0] idx);
        logic [15:0] entry;
        entry = 16'h0000;
        for (int i = 0; i < NUM_CMDS; i++) begin
            if (idx == 6'(i)) begin
                entry = CMD_TABLE[16*i +: 16];
            end
        end
        return entry;
    endfunction

    state_t               r_state;
    owner_t               r_owner;
    logic                 r_sw_is_wr;
    logic                 r_fail;
    logic [RETRY_W-1:0]   r_retry;
    logic [11:0]          r_timeout_cnt;
    logic [7:0]           r_rd_capture;
    logic [7:0]           r_sw_rd_data;
    logic                 r_sw_rd_valid;
    logic                 r_sw_error;
    logic                 r_codec_rd_en;
    logic                 r_codec_wr_en;
    logic [7:0]           r_codec_reg_addr;
    logic [7:0]           r_codec_data_in;
    logic                 r_init_done;
    logic                 r_init_error;
    logic                 r_seq_busy;
    logic [5:0]           r_cmd_index;

    logic                 w_sw_req;
    logic                 w_accept;
    logic [15:0]          w_entry_first;
    logic [15:0]          w_entry_next;

    assign w_sw_req      = sw_rd_en | sw_wr_en;
    // Start wins over a software request in the same cycle.
    assign w_accept      = (r_state == S_READY) & ~start & w_sw_req;
    assign w_entry_first = table_entry(6'd0);
    assign w_entry_next  = table_entry(r_cmd_index + 6'd1);

    // Acceptance must be visible in the request cycle, so it is decoded
    // directly from the state register (IDLE during reset, hence 0).
    assign sw_req_ack     = w_accept;
    assign sw_rd_data     = r_sw_rd_data;
    assign sw_rd_valid    = r_sw_rd_valid;
    assign sw_error       = r_sw_error;
    assign codec_rd_en    = r_codec_rd_en;
    assign codec_wr_en    = r_codec_wr_en;
    assign codec_reg_addr = r_codec_reg_addr;
    assign codec_data_in  = r_codec_data_in;
    assign init_done      = r_init_done;
    assign init_error     = r_init_error;
    assign seq_busy       = r_seq_busy;
    assign cmd_index      = r_cmd_index;

    // Sequencer FSM with all registered outputs, counters and captured data.
    always_ff @(posedge board_clk or negedge resetn) begin
        if (!resetn) begin
            r_state          <= S_IDLE;
            r_owner          <= OWN_INIT;
            r_sw_is_wr       <= 1'b0;
            r_fail           <= 1'b0;
            r_retry          <= {RETRY_W{1'b0}};
            r_timeout_cnt    <= 12'd0;
            r_rd_capture     <= 8'h00;
            r_sw_rd_data     <= 8'h00;
            r_sw_rd_valid    <= 1'b0;
            r_sw_error       <= 1'b0;
            r_codec_rd_en    <= 1'b0;
            r_codec_wr_en    <= 1'b0;
            r_codec_reg_addr <= 8'h00;
            r_codec_data_in  <= 8'h00;
            r_init_done      <= 1'b0;
            r_init_error     <= 1'b0;
            r_seq_busy       <= 1'b0;
            r_cmd_index      <= 6'd0;
        end else begin
            // Pulse outputs default low every cycle.
            r_codec_rd_en <= 1'b0;
            r_codec_wr_en <= 1'b0;
            r_sw_rd_valid <= 1'b0;
            r_sw_error    <= 1'b0;

            case (r_state)
                S_IDLE, S_READY: begin
                    if (start) begin
                        r_init_done      <= 1'b0;
                        r_init_error     <= 1'b0;
                        r_cmd_index      <= 6'd0;
                        r_owner          <= OWN_INIT;
                        r_retry          <= {RETRY_W{1'b0}};
                        r_codec_reg_addr <= w_entry_first[15:8];
                        r_codec_data_in  <= w_entry_first[7:0];
                        r_seq_busy       <= 1'b1;
                        r_state          <= S_ISSUE;
                    end else if (w_accept) begin
                        r_owner          <= OWN_SW;
                        r_sw_is_wr       <= sw_wr_en;
                        r_retry          <= {RETRY_W{1'b0}};
                        r_codec_reg_addr <= sw_reg_addr;
                        r_codec_data_in  <= sw_wr_data;
                        r_seq_busy       <= 1'b1;
                        r_state          <= S_ISSUE;
                    end else begin
                        r_state <= r_state;
                    end
                end

                S_ISSUE: begin
                    if (r_owner == OWN_SW) begin
                        r_codec_wr_en <= r_sw_is_wr;
                        r_codec_rd_en <= ~r_sw_is_wr;
                    end else begin
                        r_codec_wr_en <= 1'b1;
                    end
                    r_fail        <= 1'b0;
                    r_timeout_cnt <= 12'd0;
                    r_state       <= S_WAIT_BUSY;
                end

                S_WAIT_BUSY: begin
                    if (controller_busy) begin
                        r_fail  <= missed_ack;
                        r_state <= S_WAIT_DONE;
                    end else if (r_timeout_cnt == TIMEOUT_LAST) begin
                        // Controller never picked the strobe up.
                        r_fail  <= 1'b1;
                        r_state <= S_CHECK;
                    end else if (r_timeout_cnt != 12'hFFF) begin
                        r_timeout_cnt <= r_timeout_cnt + 12'd1;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt;
                    end
                end

                S_WAIT_DONE: begin
                    if (codec_data_out_valid) begin
                        r_rd_capture <= codec_data_out;
                    end else begin
                        r_rd_capture <= r_rd_capture;
                    end
                    // A NACK at any point of the busy window, including the
                    // cycle busy drops, fails the attempt.
                    r_fail <= r_fail | missed_ack;
                    if (!controller_busy) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_state <= S_WAIT_DONE;
                    end
                end

                S_CHECK: begin
                    if (r_fail && (r_retry < RETRY_LIMIT)) begin
                        r_retry <= r_retry + {{(RETRY_W-1){1'b0}}, 1'b1};
                        r_state <= S_ISSUE;
                    end else begin
                        r_retry <= {RETRY_W{1'b0}};
                        if (r_owner == OWN_INIT) begin
                            if (r_fail) begin
                                // cmd_index is left on the failing entry.
                                r_init_error <= 1'b1;
                                r_seq_busy   <= 1'b0;
                                r_state      <= S_READY;
                            end else if (r_cmd_index < LAST_IDX) begin
                                r_cmd_index      <= r_cmd_index + 6'd1;
                                r_codec_reg_addr <= w_entry_next[15:8];
                                r_codec_data_in  <= w_entry_next[7:0];
                                r_state          <= S_ISSUE;
                            end else begin
                                r_init_done <= 1'b1;
                                r_seq_busy  <= 1'b0;
                                r_state     <= S_READY;
                            end
                        end else begin
                            if (r_fail) begin
                                r_sw_error <= 1'b1;
                            end else if (!r_sw_is_wr) begin
                                r_sw_rd_valid <= 1'b1;
                                r_sw_rd_data  <= r_rd_capture;
                            end else begin
                                r_sw_rd_data <= r_sw_rd_data;
                            end
                            r_seq_busy <= 1'b0;
                            r_state    <= S_READY;
                        end
                    end
                end

                default: begin
                    r_seq_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// Directed testbench for codec_cfg_sequencer with a small I2C controller model.
// -----------------------------------------------------------------------------
module tb_codec_cfg_sequencer;

    logic        board_clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        sw_rd_en = 1'b0;
    logic        sw_wr_en = 1'b0;
    logic [7:0]  sw_reg_addr = 8'h00;
    logic [7:0]  sw_wr_data = 8'h00;
    logic        sw_req_ack;
    logic [7:0]  sw_rd_data;
    logic        sw_rd_valid;
    logic        sw_error;
    logic        codec_rd_en;
    logic        codec_wr_en;
    logic [7:0]  codec_reg_addr;
    logic [7:0]  codec_data_in;
    logic [7:0]  codec_data_out = 8'h00;
    logic        codec_data_out_valid = 1'b0;
    logic        controller_busy = 1'b0;
    logic        missed_ack = 1'b0;
    logic        init_done;
    logic        init_error;
    logic        seq_busy;
    logic [5:0]  cmd_index;

    int n_checks = 0;
    int n_errors = 0;

    // Controller model configuration (written by the stimulus only).
    logic        model_no_busy = 1'b0;
    logic        miss_en = 1'b0;
    logic        miss_always = 1'b0;
    logic [7:0]  miss_addr = 8'h00;
    int          miss_limit = 0;
    logic [7:0]  rd_value = 8'hA5;

    // Controller model state and observation counters (written by the model only).
    int          cyc = 0;
    int          n_wr = 0;
    int          n_rd = 0;
    int          n_addr06 = 0;
    int          n_miss = 0;
    int          n_rd_valid = 0;
    int          n_sw_err = 0;
    int          busy_left = 0;
    int          last_strobe_cyc = 0;
    int          gap = 0;
    logic        cur_miss = 1'b0;
    logic        cur_rd = 1'b0;
    logic [7:0]  log_addr [0:63];
    logic [7:0]  log_data [0:63];
    logic        log_is_wr [0:63];

    codec_cfg_sequencer #(
        .NUM_CMDS     (3),
        .CMD_TABLE    ({16'h0610, 16'h0417, 16'h1E00}),
        .MAX_RETRY    (3),
        .BUSY_TIMEOUT (4095)
    ) dut (
        .board_clk            (board_clk),
        .resetn               (resetn),
        .start                (start),
        .sw_rd_en             (sw_rd_en),
        .sw_wr_en             (sw_wr_en),
        .sw_reg_addr          (sw_reg_addr),
        .sw_wr_data           (sw_wr_data),
        .sw_req_ack           (sw_req_ack),
        .sw_rd_data           (sw_rd_data),
        .sw_rd_valid          (sw_rd_valid),
        .sw_error             (sw_error),
        .codec_rd_en          (codec_rd_en),
        .codec_wr_en          (codec_wr_en),
        .codec_reg_addr       (codec_reg_addr),
        .codec_data_in        (codec_data_in),
        .codec_data_out       (codec_data_out),
        .codec_data_out_valid (codec_data_out_valid),
        .controller_busy      (controller_busy),
        .missed_ack           (missed_ack),
        .init_done            (init_done),
        .init_error           (init_error),
        .seq_busy             (seq_busy),
        .cmd_index            (cmd_index)
    );

    always #5 board_clk = ~board_clk;

    // I2C controller model: on a strobe, busy for 20 cycles; NACK and read
    // data are presented mid-transaction.
    always @(negedge board_clk) begin
        cyc = cyc + 1;
        missed_ack = 1'b0;
        codec_data_out_valid = 1'b0;
        if (!resetn) begin
            controller_busy = 1'b0;
            busy_left = 0;
        end else begin
            if (sw_rd_valid) n_rd_valid = n_rd_valid + 1;
            if (sw_error) n_sw_err = n_sw_err + 1;
            if (busy_left > 0) begin
                busy_left = busy_left - 1;
                if (busy_left == 10) begin
                    missed_ack = cur_miss;
                    codec_data_out_valid = cur_rd;
                    codec_data_out = rd_value;
                end
                if (busy_left == 0) controller_busy = 1'b0;
            end else if (codec_wr_en || codec_rd_en) begin
                log_addr[(n_wr + n_rd) % 64] = codec_reg_addr;
                log_data[(n_wr + n_rd) % 64] = codec_data_in;
                log_is_wr[(n_wr + n_rd) % 64] = codec_wr_en;
                if (codec_wr_en) n_wr = n_wr + 1;
                else n_rd = n_rd + 1;
                if (codec_reg_addr == 8'h06) n_addr06 = n_addr06 + 1;
                gap = cyc - last_strobe_cyc;
                last_strobe_cyc = cyc;
                cur_rd = codec_rd_en;
                cur_miss = miss_en && (codec_reg_addr == miss_addr) &&
                           (miss_always || (n_miss < miss_limit));
                if (cur_miss) n_miss = n_miss + 1;
                if (!model_no_busy) begin
                    controller_busy = 1'b1;
                    busy_left = 20;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge board_clk); #1;
            n++;
        end while (seq_busy && n < budget);
        chk(tag, {63'd0, seq_busy}, 64'd0);
    endtask

    task automatic pulse_start();
        @(negedge board_clk); #1;
        start = 1'b1;
        @(negedge board_clk); #1;
        start = 1'b0;
    endtask

    task automatic sw_req(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] data, input logic exp_ack, input string tag);
        @(negedge board_clk); #1;
        sw_rd_en = rd;
        sw_wr_en = wr;
        sw_reg_addr = addr;
        sw_wr_data = data;
        #1;
        chk(tag, {63'd0, sw_req_ack}, {63'd0, exp_ack});
        @(negedge board_clk); #1;
        sw_rd_en = 1'b0;
        sw_wr_en = 1'b0;
    endtask

    initial begin
        int base_wr;
        int base_rd;
        int base_06;
        int base_val;
        int base_err;
        int n;

        // Reset state: every output low.
        repeat (3) @(negedge board_clk);
        #1;
        chk("reset_outputs",
            {26'd0, sw_req_ack, sw_rd_data, sw_rd_valid, sw_error, codec_rd_en, codec_wr_en,
             codec_reg_addr, codec_data_in, init_done, init_error, seq_busy, cmd_index},
            64'd0);
        resetn = 1'b1;
        repeat (10) @(negedge board_clk);
        #1;
        chk("idle_after_reset", {56'd0, n_wr[3:0], seq_busy, init_done, init_error, 1'b0}, 64'd0);

        // Clean init walk: three writes 1E/04/06 with data 00/17/10.
        pulse_start();
        wait_idle(2000, "init_clean_timeout");
        chk("init_clean_status", {54'd0, init_done, init_error, 2'b00, cmd_index}, {54'd0, 1'b1, 1'b0, 2'b00, 6'd2});
        chk("init_clean_strobes", 64'(n_wr), 64'd3);
        chk("init_clean_addrs", {40'd0, log_addr[0], log_addr[1], log_addr[2]}, {40'd0, 24'h1E0406});
        chk("init_clean_data", {40'd0, log_data[0], log_data[1], log_data[2]}, {40'd0, 24'h001710});

        // Restart from READY clears status; software request during init is dropped.
        base_wr = n_wr;
        pulse_start();
        chk("restart_clears_done", {62'd0, init_done, seq_busy}, {62'd0, 1'b0, 1'b1});
        repeat (5) @(negedge board_clk);
        sw_req(1'b1, 1'b0, 8'h08, 8'h00, 1'b0, "sw_during_init_ack");
        wait_idle(2000, "restart_timeout");
        chk("restart_strobes", {32'(n_wr - base_wr), 32'(n_rd)}, {32'd3, 32'd0});

        // Software read in READY.
        rd_value = 8'hA5;
        sw_req(1'b1, 1'b0, 8'h08, 8'h00, 1'b1, "sw_read_ack");
        wait_idle(200, "sw_read_timeout");
        chk("sw_read_data", {56'd0, sw_rd_data}, {56'd0, 8'hA5});
        chk("sw_read_valid_count", 64'(n_rd_valid), 64'd1);
        chk("sw_read_codec_addr", {55'd0, log_is_wr[6], log_addr[6]}, {55'd0, 1'b0, 8'h08});

        // Both strobes high is a write; no valid pulse, read data unchanged.
        sw_req(1'b1, 1'b1, 8'h22, 8'h5A, 1'b1, "sw_write_ack");
        wait_idle(200, "sw_write_timeout");
        chk("sw_write_strobe", {47'd0, log_is_wr[7], log_addr[7], log_data[7]}, {47'd0, 1'b1, 8'h22, 8'h5A});
        chk("sw_write_no_valid", {24'd0, 32'(n_rd_valid), sw_rd_data}, {24'd0, 32'd1, 8'hA5});

        // Entry 1 NACKs twice then succeeds: 5 write strobes total.
        base_wr = n_wr;
        miss_en = 1'b1;
        miss_always = 1'b0;
        miss_addr = 8'h04;
        miss_limit = n_miss + 2;
        pulse_start();
        wait_idle(5000, "retry_ok_timeout");
        chk("retry_ok_strobes", 64'(n_wr - base_wr), 64'd5);
        chk("retry_ok_status", {54'd0, init_done, init_error, 2'b00, cmd_index}, {54'd0, 1'b1, 1'b0, 2'b00, 6'd2});

        // Entry 1 always NACKs: 1 + 4 strobes, error on entry 1, entry 2 untouched.
        base_wr = n_wr;
        base_06 = n_addr06;
        miss_always = 1'b1;
        pulse_start();
        wait_idle(5000, "retry_fail_timeout");
        chk("retry_fail_strobes", 64'(n_wr - base_wr), 64'd5);
        chk("retry_fail_status", {54'd0, init_done, init_error, 2'b00, cmd_index}, {54'd0, 1'b0, 1'b1, 2'b00, 6'd1});
        chk("retry_fail_entry2", 64'(n_addr06 - base_06), 64'd0);

        // Software read still works after init_error.
        miss_en = 1'b0;
        rd_value = 8'hC3;
        sw_req(1'b1, 1'b0, 8'h08, 8'h00, 1'b1, "sw_after_err_ack");
        wait_idle(200, "sw_after_err_timeout");
        chk("sw_after_err_data", {56'd0, sw_rd_data}, {56'd0, 8'hC3});

        // Software read exhausting retries: error pulse, data unchanged.
        base_rd = n_rd;
        base_val = n_rd_valid;
        base_err = n_sw_err;
        miss_en = 1'b1;
        miss_addr = 8'h08;
        rd_value = 8'h3C;
        sw_req(1'b1, 1'b0, 8'h08, 8'h00, 1'b1, "sw_exhaust_ack");
        wait_idle(500, "sw_exhaust_timeout");
        chk("sw_exhaust_counts", {16'd0, 16'(n_rd - base_rd), 16'(n_rd_valid - base_val), 16'(n_sw_err - base_err)},
            {16'd0, 16'd4, 16'd0, 16'd1});
        chk("sw_exhaust_data", {56'd0, sw_rd_data}, {56'd0, 8'hC3});
        miss_en = 1'b0;
        miss_always = 1'b0;

        // Controller never goes busy: 4 attempts, each timing out after 4095 cycles.
        base_wr = n_wr;
        model_no_busy = 1'b1;
        pulse_start();
        wait_idle(20000, "no_busy_timeout");
        chk("no_busy_strobes", 64'(n_wr - base_wr), 64'd4);
        chk("no_busy_status", {54'd0, init_done, init_error, 2'b00, cmd_index}, {54'd0, 1'b0, 1'b1, 2'b00, 6'd0});
        chk("no_busy_gap", 64'(gap), 64'd4097);
        model_no_busy = 1'b0;

        // Reset in WAIT_DONE of entry 1, then a fresh start from entry 0.
        base_wr = n_wr;
        pulse_start();
        n = 0;
        while (!((n_wr - base_wr) == 2 && controller_busy) && n < 500) begin
            @(negedge board_clk); #1;
            n++;
        end
        chk("reach_wait_done", {63'd0, controller_busy}, 64'd1);
        repeat (3) @(negedge board_clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("async_reset_outputs",
            {26'd0, sw_req_ack, sw_rd_data, sw_rd_valid, sw_error, codec_rd_en, codec_wr_en,
             codec_reg_addr, codec_data_in, init_done, init_error, seq_busy, cmd_index},
            64'd0);
        repeat (3) @(negedge board_clk);
        #1;
        resetn = 1'b1;
        base_wr = n_wr;
        repeat (10) @(negedge board_clk);
        #1;
        chk("idle_after_abort", {31'd0, seq_busy, 32'(n_wr - base_wr)}, 64'd0);
        pulse_start();
        wait_idle(2000, "restart_after_reset_timeout");
        chk("restart_first_addr", {56'd0, log_addr[base_wr % 64]}, {56'd0, 8'h1E});
        chk("restart_status", {54'd0, init_done, init_error, 2'b00, cmd_index}, {54'd0, 1'b1, 1'b0, 2'b00, 6'd2});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
